audio_level_meter: RTL and testbench
====================================

# audio_level_meter

Downstream consumer of the 16-sample microphone frame produced by the sampler stage. On each new frame it removes the DC offset, computes the sum of absolute deviations, and quantises it to a 4-bit log2 bar level. It also maintains a decaying peak-hold level for the visualizer's bar renderer. Processing is fully serial: one sample per clock.

## Interface
Parameters:
- DECAY_DIV, default 1250000: clk_25 cycles per peak-decay step (50 ms at 25 MHz); must be ≥ 2.

Ports:
- clk_25  input  1  25 MHz system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- done_in  input  1  frame-ready level from the sampler, synchronous to clk_25; a frame is signalled by its rising edge.
- s0 … s15  input  18 each  frame samples; the 12-bit ADC code is in bits [17:6], and bits [5:0] are ignored. Stable while done_in is high.
- level  output  4  latest frame level, 0–15.
- level_valid  output  1  one-cycle pulse when level updates.
- peak  output  4  peak-hold level.
- busy  output  1  high while a frame is being processed.
- drop_cnt  output  8  saturating count of frames ignored while busy.

## Operation
- Edge detect: done_q is a register of done_in and resets to 1, so a done_in already high at reset release is not a frame. A frame event is done_in=1 and done_q=0.
- States: IDLE → SUM → DEV → QUANT → IDLE.
- IDLE: on a frame event, latch s_i[17:6] into a 16×12 buffer, clear acc and idx, and go to SUM.
- SUM, 16 cycles, idx 0..15: acc += buf[idx]. acc is 16 bits; the maximum is 65520, so it cannot overflow. After idx 15: mean = acc[15:4] (truncate), clear acc, clear idx, go to DEV.
- DEV, 16 cycles: acc += |buf[idx] − mean|, computed in 13-bit signed arithmetic and then taking the magnitude. The maximum is 16×4095, so acc fits in 16 bits. After idx 15, go to QUANT.
- QUANT, 1 cycle:
  - level ← index of the highest set bit of acc, or 0 if acc == 0.
  - Pulse level_valid.
  - Update peak, then go to IDLE.
- Peak hold:
  - A free-running decay counter counts 0..DECAY_DIV−1 in every state.
  - On wrap, if peak > level, peak decrements by 1.
  - On a QUANT edge with new level ≥ peak: peak ← new level and the counter resets to 0. This overrides a wrap on the same edge.
  - On a QUANT edge with new level < peak: peak is unchanged and the counter continues.
- Frame event while not IDLE: the frame is ignored, drop_cnt increments and saturates at 255, and the current computation is unaffected.
- The buffer is only written in IDLE on a frame event. Input changes during processing have no effect.

## Timing
- Reset values: level=0, peak=0, level_valid=0, busy=0, drop_cnt=0, state IDLE, decay counter 0, done_q=1.
- Reset asserted mid-frame returns everything to these reset values immediately. The partial result is discarded and no level_valid is produced.
- Let edge k be the edge that detects the frame event and loads the buffer.
- busy is high from after edge k to after edge k+33.
- SUM occupies edges k+1..k+16; DEV occupies edges k+17..k+32; QUANT is edge k+33.
- level, peak and level_valid update at edge k+33. level_valid is high for exactly the cycle after it.
- The earliest next accepted frame event is edge k+34 (IDLE). Minimum frame spacing is 34 cycles.
- A frame event exactly at edge k+33 is still dropped.
- level and peak hold their value between updates; peak changes otherwise only by decay.

## Test plan
- All 16 samples = 2048<<6, one done_in rising edge → level_valid at k+33, level=0, peak=0, drop_cnt=0.
- Even-index samples 0, odd-index 4095 → mean=2047, deviation sum=32760, level=14 and peak=14 at k+33.
- All samples 2048 except s0=2112 → mean=2052, deviation sum=120, level=6.
- DECAY_DIV=4, level-14 frame then all-2048 frame → peak steps 14→13→…→0, one step per 4 cycles after the wrap, and stops at 0; level=0.
- Second done_in rising edge at k+10 with different samples → ignored, drop_cnt=1, and the first frame's level is unchanged at k+33. A third event after k+34 is accepted normally.
- rst pulsed at k+20 → all outputs return to reset values, no level_valid appears, and a following frame completes normally 33 cycles after its event.

Source files
------------

// File: rtl/audio_level_meter.sv
// Audio level meter: per-frame DC removal, sum of absolute deviations, log2 bar level,
// and a decaying peak-hold level. One sample is processed per clock.
module audio_level_meter #(
    parameter int unsigned DECAY_DIV = 1250000
) (
    input  logic        clk_25,
    input  logic        rst,
    input  logic        done_in,
    input  logic [17:0] s0,
    input  logic [17:0] s1,
    input  logic [17:0] s2,
    input  logic [17:0] s3,
    input  logic [17:0] s4,
    input  logic [17:0] s5,
    input  logic [17:0] s6,
    input  logic [17:0] s7,
    input  logic [17:0] s8,
    input  logic [17:0] s9,
    input  logic [17:0] s10,
    input  logic [17:0] s11,
    input  logic [17:0] s12,
    input  logic [17:0] s13,
    input  logic [17:0] s14,
    input  logic [17:0] s15,
    output logic [3:0]  level,
    output logic        level_valid,
    output logic [3:0]  peak,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned CntW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSum,
        StDev,
        StQuant
    } state_e;

    state_e            state_q, state_d;
    logic              done_q;
    logic [11:0]       frame_q [16];
    logic [11:0]       samp [16];
    logic              load;
    logic [15:0]       acc_q, acc_d;
    logic [3:0]        idx_q, idx_d;
    logic [11:0]       mean_q, mean_d;
    logic [3:0]        level_q, level_d;
    logic              level_valid_q, level_valid_d;
    logic [3:0]        peak_q, peak_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        drop_q, drop_d;

    logic              frame_evt;
    logic              quant;
    logic              wrap;
    logic [11:0]       cur;
    logic [15:0]       sum;
    logic [12:0]       diff;
    logic [12:0]       mag;

    // ADC code lives in the top 12 bits; the low 6 bits are padding.
    logic unused_lsbs;
    assign unused_lsbs = ^{s0[5:0], s1[5:0], s2[5:0], s3[5:0], s4[5:0], s5[5:0],
                           s6[5:0], s7[5:0], s8[5:0], s9[5:0], s10[5:0], s11[5:0],
                           s12[5:0], s13[5:0], s14[5:0], s15[5:0]};

    always_comb begin
        samp[0]  = s0[17:6];
        samp[1]  = s1[17:6];
        samp[2]  = s2[17:6];
        samp[3]  = s3[17:6];
        samp[4]  = s4[17:6];
        samp[5]  = s5[17:6];
        samp[6]  = s6[17:6];
        samp[7]  = s7[17:6];
        samp[8]  = s8[17:6];
        samp[9]  = s9[17:6];
        samp[10] = s10[17:6];
        samp[11] = s11[17:6];
        samp[12] = s12[17:6];
        samp[13] = s13[17:6];
        samp[14] = s14[17:6];
        samp[15] = s15[17:6];
    end

    function automatic logic [3:0] msb_idx(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    always_comb begin
        frame_evt     = done_in & ~done_q;
        state_d       = state_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        mean_d        = mean_q;
        level_d       = level_q;
        level_valid_d = 1'b0;
        load          = 1'b0;
        quant         = 1'b0;
        cur           = frame_q[idx_q];
        sum           = acc_q + 16'(cur);
        diff          = {1'b0, cur} - {1'b0, mean_q};
        mag           = diff[12] ? (~diff + 13'd1) : diff;

        unique case (state_q)
            StIdle: begin
                if (frame_evt) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StSum;
                end
            end
            StSum: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    mean_d  = sum[15:4];
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StDev;
                end else begin
                    acc_d = sum;
                end
            end
            StDev: begin
                acc_d = acc_q + 16'(mag);
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) state_d = StQuant;
            end
            StQuant: begin
                level_d       = msb_idx(acc_q);
                level_valid_d = 1'b1;
                quant         = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Peak hold: a new level at or above the peak reloads it and restarts the decay period.
    always_comb begin
        wrap   = (cnt_q == CntW'(DECAY_DIV - 1));
        cnt_d  = wrap ? '0 : cnt_q + CntW'(1);
        peak_d = peak_q;
        if (quant && (level_d >= peak_q)) begin
            peak_d = level_d;
            cnt_d  = '0;
        end else if (wrap && (peak_q > level_d)) begin
            peak_d = peak_q - 4'd1;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (frame_evt && (state_q != StIdle) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            done_q        <= 1'b1;
            acc_q         <= '0;
            idx_q         <= '0;
            mean_q        <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
            peak_q        <= '0;
            cnt_q         <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_in;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            mean_q        <= mean_d;
            level_q       <= level_d;
            level_valid_q <= level_valid_d;
            peak_q        <= peak_d;
            cnt_q         <= cnt_d;
            drop_q        <= drop_d;
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) frame_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) frame_q[i] <= samp[i];
        end
    end

    assign level       = level_q;
    assign level_valid = level_valid_q;
    assign peak        = peak_q;
    assign busy        = (state_q != StIdle);
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Scoreboard bench for audio_level_meter: stimulus queues expected results, a negedge
// monitor checks each level_valid pulse against the queue head.
module tb_audio_level_meter;

    localparam int unsigned Decay = 4;

    logic        clk_25 = 1'b0;
    logic        rst;
    logic        done_in;
    logic [17:0] s [16];
    logic [3:0]  level;
    logic        level_valid;
    logic [3:0]  peak;
    logic        busy;
    logic [7:0]  drop_cnt;

    typedef struct {
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] pk;
        bit         chk_pk;
    } exp_t;

    exp_t exp_q [$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    audio_level_meter #(.DECAY_DIV(Decay)) dut (
        .clk_25      (clk_25),
        .rst         (rst),
        .done_in     (done_in),
        .s0          (s[0]),
        .s1          (s[1]),
        .s2          (s[2]),
        .s3          (s[3]),
        .s4          (s[4]),
        .s5          (s[5]),
        .s6          (s[6]),
        .s7          (s[7]),
        .s8          (s[8]),
        .s9          (s[9]),
        .s10         (s[10]),
        .s11         (s[11]),
        .s12         (s[12]),
        .s13         (s[13]),
        .s14         (s[14]),
        .s15         (s[15]),
        .level       (level),
        .level_valid (level_valid),
        .peak        (peak),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #20 clk_25 = ~clk_25;
    always @(posedge clk_25) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every level_valid pulse must match the oldest queued expectation.
    always @(negedge clk_25) begin
        if (!rst && level_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_level_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("level", int'(level), int'(e.lvl));
                if (e.chk_pk) check("peak", int'(peak), int'(e.pk));
            end
        end
    end

    task automatic set_all(input logic [11:0] v);
        for (int i = 0; i < 16; i++) s[i] = {v, 6'h2A};
    endtask

    task automatic set_alt();
        for (int i = 0; i < 16; i++) s[i] = (i % 2 == 0) ? {12'd0, 6'h00} : {12'd4095, 6'h3F};
    endtask

    task automatic set_spike();
        set_all(12'd2048);
        s[0] = {12'd2112, 6'h15};
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk_25);
    endtask

    // Raise done_in so that edge e detects the frame event; returns at the negedge after e.
    task automatic pulse_done_at(input int e);
        wait_to(e - 1);
        done_in = 1'b1;
        @(negedge clk_25);
        done_in = 1'b0;
    endtask

    task automatic push(input int c, input int lvl, input int pk, input bit chk);
        exp_t e;
        e.cyc = c;
        e.lvl = 4'(lvl);
        e.pk = 4'(pk);
        e.chk_pk = chk;
        exp_q.push_back(e);
    endtask

    task automatic run_frame(input int lvl, input int pk, input bit chk);
        int k;
        k = cyc + 2;
        push(k + 33, lvl, pk, chk);
        pulse_done_at(k);
        check("busy_after_event", int'(busy), 1);
        wait_to(k + 32);
        check("busy_before_quant", int'(busy), 1);
        wait_to(k + 33);
        check("busy_after_quant", int'(busy), 0);
        wait_to(k + 35);
    endtask

    task automatic check_reset_outputs();
        check("rst_level", int'(level), 0);
        check("rst_peak", int'(peak), 0);
        check("rst_level_valid", int'(level_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int k2;
        int prev;
        int last;
        int steps;

        rst = 1'b1;
        done_in = 1'b1;
        set_all(12'd2048);
        repeat (3) @(negedge clk_25);
        check_reset_outputs();
        rst = 1'b0;
        // done_in already high at reset release must not start a frame.
        repeat (4) @(negedge clk_25);
        check("no_frame_on_high_done", int'(busy), 0);
        done_in = 1'b0;
        @(negedge clk_25);

        set_all(12'd2048);
        run_frame(0, 0, 1'b1);
        check("drop_cnt_idle", int'(drop_cnt), 0);

        set_alt();
        run_frame(14, 14, 1'b1);

        set_spike();
        run_frame(6, 0, 1'b0);
        repeat (10) @(negedge clk_25);

        set_alt();
        run_frame(14, 14, 1'b1);

        // Level-0 frame after a level-14 frame: peak decays one step per Decay cycles.
        set_all(12'd2048);
        k = cyc + 2;
        push(k + 33, 0, 0, 1'b0);
        pulse_done_at(k);
        wait_to(k + 32);
        check("peak_before_decay", int'(peak), 14);
        prev = 14;
        last = -1;
        steps = 0;
        repeat (80) begin
            @(negedge clk_25);
            if (int'(peak) != prev) begin
                check("decay_step", int'(peak), prev - 1);
                if (last >= 0) check("decay_period", cyc - last, Decay);
                last = cyc;
                steps++;
                prev = int'(peak);
            end
        end
        check("decay_steps", steps, 14);
        check("peak_final", int'(peak), 0);
        check("level_after_decay", int'(level), 0);

        // Events at k+10 and k+33 arrive while busy and are dropped.
        set_alt();
        k = cyc + 2;
        push(k + 33, 14, 14, 1'b1);
        pulse_done_at(k);
        set_all(12'd2048);
        pulse_done_at(k + 10);
        check("drop_cnt_mid_frame", int'(drop_cnt), 1);
        pulse_done_at(k + 33);
        wait_to(k + 34);
        check("drop_cnt_at_quant", int'(drop_cnt), 2);
        wait_to(k + 36);

        // Event at k+34 is the earliest accepted one.
        set_all(12'd2048);
        k2 = cyc + 2;
        push(k2 + 33, 0, 0, 1'b0);
        pulse_done_at(k2);
        set_spike();
        push(k2 + 34 + 33, 6, 0, 1'b0);
        pulse_done_at(k2 + 34);
        check("busy_back_to_back", int'(busy), 1);
        wait_to(k2 + 34 + 35);
        check("drop_cnt_min_spacing", int'(drop_cnt), 2);

        // Reset mid-frame discards the computation.
        set_alt();
        k = cyc + 2;
        push(k + 33, 14, 14, 1'b1);
        pulse_done_at(k);
        wait_to(k + 19);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk_25);
        check_reset_outputs();
        rst = 1'b0;
        repeat (40) @(negedge clk_25);
        check("no_valid_after_reset", exp_q.size(), 0);

        set_alt();
        run_frame(14, 14, 1'b1);
        repeat (3) @(negedge clk_25);

        check("pending_expected", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
